// File: rtl/ddr_fifo_pkg.sv
// Shared types and constants for the burst pattern checker.
package ddr_fifo_pkg;

  localparam int unsigned DEFAULT_BURST_LEN = 256;
  localparam int unsigned PATTERN_W         = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_BURST  = 2'd1;
  localparam state_t ST_REPORT = 2'd2;

  function automatic logic [31:0] replicate(input logic [PATTERN_W-1:0] v);
    return {4{v}};
  endfunction

endpackage

// File: rtl/expected_pattern_gen.sv
// Word index counter and the expected {4{idx}} data word derived from it.
module expected_pattern_gen
  import ddr_fifo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clear,
  output logic [PATTERN_W-1:0] idx,
  output logic [31:0]          expected
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     idx <= '0;
    else if (clear) idx <= '0;
    else if (inc)   idx <= idx + 1'b1;
  end

  assign expected = replicate(idx);

endmodule

// File: rtl/pattern_checker.sv
// Burst data-pattern checker with statistics counters and sticky flags.
// Optional first-mismatch capture ports enabled by PATTERN_CHECKER_FIRST_ERR_EN.
module pattern_checker
  import ddr_fifo_pkg::*;
#(
  parameter int unsigned BURST_LEN   = DEFAULT_BURST_LEN,
  parameter int unsigned GAP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] DataIn,
  input  logic        DataInValid,
  input  logic        ClearStats,
  output logic        Busy,
  output logic        BurstDone,
  output logic        BurstOk,
  output logic [15:0] BurstCount,
  output logic [15:0] ErrCount,
  output logic        ErrSticky,
`ifdef PATTERN_CHECKER_FIRST_ERR_EN
  output logic [31:0] FirstErrData,
  output logic [31:0] FirstErrExp,
  output logic [7:0]  FirstErrIdx,
`endif
  output logic        ShortSticky
);

  localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam logic [PATTERN_W-1:0] LAST_IDX = PATTERN_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

  state_t                state, next_state;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  burst_err;
  logic [PATTERN_W-1:0]  idx;
  logic [31:0]           expected;
  logic                  mismatch, inc, clr, end_burst, ok_next, timeout;

  expected_pattern_gen u_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc),
    .clear    (clr),
    .idx      (idx),
    .expected (expected)
  );

  // idx is already 0 in IDLE/REPORT, so a starting word is checked against pattern 0
  assign mismatch = DataInValid && (DataIn != expected);

  always_comb begin
    next_state = state;
    inc        = 1'b0;
    clr        = 1'b0;
    end_burst  = 1'b0;
    ok_next    = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE, ST_REPORT: begin
        next_state = DataInValid ? ST_BURST : ST_IDLE;
        inc        = DataInValid;
      end
      ST_BURST: begin
        if (DataInValid) begin
          if (idx == LAST_IDX) begin
            next_state = ST_REPORT;
            clr        = 1'b1;
            end_burst  = 1'b1;
            ok_next    = !burst_err && !mismatch;
          end else begin
            inc = 1'b1;
          end
        end else if (gap_cnt == GAP_LAST) begin
          next_state = ST_REPORT;
          clr        = 1'b1;
          end_burst  = 1'b1;
          timeout    = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      burst_err <= 1'b0;
      Busy      <= 1'b0;
      BurstDone <= 1'b0;
      BurstOk   <= 1'b0;
    end else begin
      state     <= next_state;
      gap_cnt   <= (state == ST_BURST && next_state == ST_BURST && !DataInValid)
                   ? gap_cnt + 1'b1 : '0;
      if (next_state == ST_BURST)
        burst_err <= ((state == ST_BURST) ? burst_err : 1'b0) | mismatch;
      else
        burst_err <= 1'b0;
      Busy      <= (next_state == ST_BURST);
      BurstDone <= end_burst;
      BurstOk   <= ok_next;
    end
  end

  // ClearStats takes priority over any same-cycle increment or flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BurstCount  <= '0;
      ErrCount    <= '0;
      ErrSticky   <= 1'b0;
      ShortSticky <= 1'b0;
    end else if (ClearStats) begin
      BurstCount  <= '0;
      ErrCount    <= '0;
      ErrSticky   <= 1'b0;
      ShortSticky <= 1'b0;
    end else begin
      if (end_burst)                   BurstCount  <= BurstCount + 16'd1;
      if (mismatch && ErrCount != '1)  ErrCount    <= ErrCount + 16'd1;
      if (mismatch)                    ErrSticky   <= 1'b1;
      if (timeout)                     ShortSticky <= 1'b1;
    end
  end

`ifdef PATTERN_CHECKER_FIRST_ERR_EN
  logic first_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_seen   <= 1'b0;
      FirstErrData <= '0;
      FirstErrExp  <= '0;
      FirstErrIdx  <= '0;
    end else if (ClearStats) begin
      first_seen   <= 1'b0;
      FirstErrData <= '0;
      FirstErrExp  <= '0;
      FirstErrIdx  <= '0;
    end else if (mismatch && !first_seen) begin
      first_seen   <= 1'b1;
      FirstErrData <= DataIn;
      FirstErrExp  <= expected;
      FirstErrIdx  <= idx;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_checker.sv
// Scoreboard bench for pattern_checker: expected burst results are queued by
// the stimulus and checked by a monitor whenever BurstDone is seen.
module tb_pattern_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] DataIn;
  logic        DataInValid;
  logic        ClearStats;
  logic        Busy, BurstDone, BurstOk, ErrSticky, ShortSticky;
  logic [15:0] BurstCount, ErrCount;
`ifdef PATTERN_CHECKER_FIRST_ERR_EN
  logic [31:0] FirstErrData, FirstErrExp;
  logic [7:0]  FirstErrIdx;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct {
    logic        ok;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pattern_checker #(.BURST_LEN(256), .GAP_TIMEOUT(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .DataIn      (DataIn),
    .DataInValid (DataInValid),
    .ClearStats  (ClearStats),
    .Busy        (Busy),
    .BurstDone   (BurstDone),
    .BurstOk     (BurstOk),
    .BurstCount  (BurstCount),
    .ErrCount    (ErrCount),
    .ErrSticky   (ErrSticky),
`ifdef PATTERN_CHECKER_FIRST_ERR_EN
    .FirstErrData(FirstErrData),
    .FirstErrExp (FirstErrExp),
    .FirstErrIdx (FirstErrIdx),
`endif
    .ShortSticky (ShortSticky)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int unsigned i);
    logic [7:0] b;
    b = i[7:0];
    return {4{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d);
    DataIn      = d;
    DataInValid = 1'b1;
    tick();
    DataInValid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    DataInValid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic push(input logic ok, input logic [15:0] cnt);
    exp_t e;
    e.ok  = ok;
    e.cnt = cnt;
    q.push_back(e);
  endtask

  // Monitor: every BurstDone pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && BurstDone === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got BurstDone=1, expected no pulse (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("burst_ok", {31'd0, BurstOk}, {31'd0, e.ok});
        check("burst_count_at_done", {16'd0, BurstCount}, {16'd0, e.cnt});
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    DataIn      = '0;
    DataInValid = 1'b0;
    ClearStats  = 1'b0;
    #23;
    check("rst_busy",       {31'd0, Busy},        32'd0);
    check("rst_done",       {31'd0, BurstDone},   32'd0);
    check("rst_ok",         {31'd0, BurstOk},     32'd0);
    check("rst_burstcount", {16'd0, BurstCount},  32'd0);
    check("rst_errcount",   {16'd0, ErrCount},    32'd0);
    check("rst_errsticky",  {31'd0, ErrSticky},   32'd0);
    check("rst_shortsticky",{31'd0, ShortSticky}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Clean full burst
    push(1'b1, 16'd1);
    for (int unsigned i = 0; i < 256; i++) send_word(pat(i));
    idle(2);
    check("clean_burstcount", {16'd0, BurstCount}, 32'd1);
    check("clean_errcount",   {16'd0, ErrCount},   32'd0);
    check("clean_busy",       {31'd0, Busy},       32'd0);

    // Word 17 corrupted
    push(1'b0, 16'd2);
    for (int unsigned i = 0; i < 256; i++) begin
      send_word((i == 17) ? 32'h1111_1110 : pat(i));
      if (i == 18) begin
        check("err_errcount", {16'd0, ErrCount},  32'd1);
        check("err_sticky",   {31'd0, ErrSticky}, 32'd1);
      end
    end
    idle(2);
    check("err_errcount_end", {16'd0, ErrCount}, 32'd1);

    // Clear, then short burst with timeout
    ClearStats = 1'b1;
    tick();
    ClearStats = 1'b0;
    check("clr_burstcount", {16'd0, BurstCount}, 32'd0);
    check("clr_errcount",   {16'd0, ErrCount},   32'd0);
    check("clr_errsticky",  {31'd0, ErrSticky},  32'd0);
    push(1'b0, 16'd1);
    for (int unsigned i = 0; i < 100; i++) send_word(pat(i));
    idle(63);
    check("gap63_busy", {31'd0, Busy}, 32'd1);
    idle(1);
    check("timeout_done", {31'd0, BurstDone}, 32'd1);
    tick();
    check("timeout_busy",   {31'd0, Busy},        32'd0);
    check("timeout_sticky", {31'd0, ShortSticky}, 32'd1);

    // Gapped burst, gaps 1..63 never time out
    ClearStats = 1'b1;
    tick();
    ClearStats = 1'b0;
    push(1'b1, 16'd1);
    for (int unsigned i = 0; i < 256; i++) begin
      send_word(pat(i));
      idle($urandom_range(63, 1));
    end
    check("gapped_shortsticky", {31'd0, ShortSticky}, 32'd0);
    check("gapped_errcount",    {16'd0, ErrCount},    32'd0);

    // Reset mid-burst discards it; next burst starts at idx 0
    for (int unsigned i = 0; i < 50; i++) send_word(pat(i));
    rst_n = 1'b0;
    #2;
    check("midrst_busy",       {31'd0, Busy},       32'd0);
    check("midrst_burstcount", {16'd0, BurstCount}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    push(1'b1, 16'd1);
    for (int unsigned i = 0; i < 256; i++) send_word(pat(i));
    idle(3);
    check("postrst_burstcount", {16'd0, BurstCount}, 32'd1);

    // ClearStats coincident with a mismatch drops the error count
    push(1'b0, 16'd1);
    ClearStats = 1'b1;
    send_word(32'hDEAD_BEEF);
    ClearStats = 1'b0;
    check("clrwin_errcount",  {16'd0, ErrCount},   32'd0);
    check("clrwin_errsticky", {31'd0, ErrSticky},  32'd0);
    check("clrwin_busy",      {31'd0, Busy},       32'd1);
    for (int unsigned i = 1; i < 256; i++) send_word(pat(i));
    idle(4);
    check("clrwin_errcount_end", {16'd0, ErrCount}, 32'd0);

    check("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_checker.md
PATTERN_CHECKER -- requirements
Module: pattern_checker

Interface
REQ-001 SHALL have parameter BURST_LEN, default 256, words per burst (power of 2, 2..256).
REQ-002 SHALL have parameter GAP_TIMEOUT, default 64, max idle cycles inside a burst before abort.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port DataIn  input  32  word under test; expected value {4{idx[7:0]}}.
REQ-006 SHALL have port DataInValid  input  1  DataIn qualifier; gaps allowed.
REQ-007 SHALL have port ClearStats  input  1  synchronous clear of counters and sticky flags.
REQ-008 SHALL have port Busy  output  1  high while in BURST state.
REQ-009 SHALL have port BurstDone  output  1  one-cycle pulse at the end of each burst, complete or aborted.
REQ-010 SHALL have port BurstOk  output  1  valid with BurstDone; 1 = full length and zero mismatches.
REQ-011 SHALL have port BurstCount  output  16  bursts ended; wraps 0xFFFF->0.
REQ-012 SHALL have port ErrCount  output  16  mismatched words; saturates at 0xFFFF.
REQ-013 SHALL have port ErrSticky  output  1  set on any mismatch.
REQ-014 SHALL have port ShortSticky  output  1  set on any timeout abort.

Function
REQ-015 SHALL implement FSM IDLE, BURST, and REPORT.
REQ-016 IDLE: DataInValid=1 -> BURST; that word has idx 0 and is checked.
REQ-017 BURST: each valid word compared to {4{idx}}; idx increments per valid word, never on gaps.
REQ-018 BURST: valid word with idx = BURST_LEN-1 -> REPORT with BurstOk = (burst mismatches == 0).
REQ-019 BURST: gap counter resets on each valid word; reaching GAP_TIMEOUT consecutive idle cycles -> REPORT with BurstOk=0 and ShortSticky set.
REQ-020 REPORT: lasts one cycle; BurstDone=1; BurstCount+1; -> IDLE; DataInValid during REPORT starts a new burst at idx 0 (next state BURST).
REQ-021 Mismatch SHALL increment ErrCount (saturating) and set ErrSticky one cycle after the offending word.
REQ-022 Latency SHALL be BurstDone one cycle after the last word, or one cycle after the timeout count is reached.
REQ-023 Any mismatch within a burst SHALL force that burst's BurstOk=0.
REQ-024 ClearStats SHALL zero BurstCount, ErrCount, ErrSticky, and ShortSticky next cycle without affecting FSM or idx.
REQ-025 ClearStats coincident with an increment or set event: clear SHALL win, and the event is dropped.
REQ-026 Busy SHALL be registered and equal (state == BURST).

Reset
REQ-027 rst_n=0 SHALL force the following, asynchronously: state IDLE, idx 0, gap counter 0, all outputs 0.
REQ-028 Reset during BURST SHALL discard the partial burst with no BurstDone pulse after release.
REQ-029 First valid word after reset release SHALL be treated as idx 0.

Configuration
REQ-030 Macro PATTERN_CHECKER_FIRST_ERR_EN defined: outputs FirstErrData[31:0], FirstErrExp[31:0], and FirstErrIdx[7:0] SHALL capture the first mismatch since reset/ClearStats and hold it.
REQ-031 Macro undefined: those ports and registers SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Shared package ddr_fifo_pkg SHALL hold the FSM state typedef, the default BURST_LEN (256), and the pattern width (8).
REQ-033 Sub-module expected_pattern_gen (idx counter plus {4{idx}} replicator, with inc/clear inputs) SHALL be instantiated once.

Verification
REQ-034 256 consecutive valid words 0x00000000..0xFFFFFFFF in the pattern -> BurstDone with BurstOk=1 one cycle after the last word; BurstCount=1, ErrCount=0.
REQ-035 Same burst with word 17 = 0x11111110 -> ErrCount=1 two cycles after it, ErrSticky=1, and BurstOk=0 at the end.
REQ-036 100 valid words followed by 64 idle cycles -> BurstDone with BurstOk=0, ShortSticky=1, and Busy=0 next cycle.
REQ-037 Burst with a random 1..63-cycle gap after every word -> BurstOk=1 and no timeout.
REQ-038 rst_n pulsed low at word 50, then a full clean burst -> exactly one BurstDone with BurstOk=1; ClearStats coincident with a mismatch -> ErrCount=0.
